dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single data-memory port between the pipeline's MEM stage (core) and an external loader/debug requester (ext). Sits between the MEM stage and the data memory, muxing address, write data, write enable and load/store type onto the memory each cycle. Core has priority; a starvation counter guarantees ext forward progress by stalling the core for one cycle. Ext uses a req/ack handshake with registered read data.

## Interface
- STARVE_LIMIT, 4: consecutive core-won contention cycles before ext is forced through (1..15).
- ADDR_W, 12: data-memory byte-address width.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- core_valid  in  1  MEM stage has a load or store this cycle
- core_mem_write  in  1  core store (1) / load (0)
- core_store_type  in  2  store size code, passed through
- core_load_type  in  3  load size/sign code, passed through
- core_addr  in  ADDR_W  core byte address
- core_wdata  in  32  core store data
- core_rdata  out  32  load data to core (combinational from memory)
- core_stall  out  1  core access not serviced this cycle; MEM stage must hold
- ext_req  in  1  ext request, held high with stable fields until ext_ack
- ext_we, ext_store_type[2], ext_load_type[3], ext_addr[ADDR_W], ext_wdata[32]  in  ext access fields
- ext_ack  out  1  one-cycle pulse: ext access completed
- ext_rdata  out  32  registered ext load data, valid with ext_ack, held until next ext load
- mem_write  out  1  to data memory write enable
- mem_store_type  out  2, mem_load_type  out  3, mem_addr  out  ADDR_W, mem_wdata  out  32  to data memory
- mem_read_data  in  32  combinational read data from data memory

## Operation
- Grant per cycle (combinational): ext_ok = ext_req & ~ext_ack.
  - ext_ok & (~core_valid | starve_cnt == STARVE_LIMIT) -> GNT_EXT.
  - else core_valid -> GNT_CORE.
  - else GNT_NONE.
- Mux: GNT_EXT drives ext fields; otherwise core fields. mem_write = core_mem_write only on GNT_CORE, ext_we only on GNT_EXT, else 0.
- core_stall = core_valid & GNT_EXT. Stalled core store never reaches memory.
- core_rdata = mem_read_data always; meaningful only when core granted and not stalled.
- starve_cnt (4 bits): GNT_EXT or ~ext_ok -> 0; GNT_CORE with ext_ok -> +1; saturates at STARVE_LIMIT.
- On GNT_EXT at edge: ext_ack <= 1; if ~ext_we, ext_rdata <= mem_read_data. Otherwise ext_ack <= 0.
- Ack cycle is a mandatory ext bubble (ext_ok = 0); ext may deassert or present a new request during it, which becomes eligible the following cycle.

## Timing
- Reset values: ext_ack 0, ext_rdata 0, starve_cnt 0; combinational outputs follow inputs (mem_write 0 unless granted).
- Core access latency 0 cycles when granted; stall is exactly one cycle per forced ext grant.
- Ext latency: grant cycle N, ext_ack high in N+1; minimum 2 cycles between back-to-back ext accesses.
- Uncontended ext (core_valid = 0): granted in first cycle ext_req high.
- Worst-case ext wait with core_valid continuously high: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT.
- Reset asserted mid-access: ack dropped, counter cleared; ext must reissue. Reset in the ack cycle clears ext_ack asynchronously.
- Simultaneous core store and ext store to same address: only granted one writes that cycle; stalled core store writes next cycle (last-writer wins).

## Structure
- Shared package dmem_arb_pkg: grant encoding GNT_NONE/GNT_CORE/GNT_EXT (2-bit), STORE_TYPE_W = 2, LOAD_TYPE_W = 3.
- One sub-module: dmem_starve_ctr (saturating counter with clear/increment, limit parameter). Grant logic, mux and ack register stay in top.

## Test plan
- Core-only: core_valid = 1 load from 0x010, memory returns 0xDEADBEEF -> core_rdata = 0xDEADBEEF same cycle, core_stall = 0, mem_write = 0.
- Ext-only: ext store word 0x12345678 to 0x020, then ext load 0x020 -> each ext_ack one cycle after grant, ext_rdata = 0x12345678, one bubble between accesses.
- Contention, STARVE_LIMIT = 4: core_valid held 1, ext_req rises cycle 0 -> core granted cycles 0-3, GNT_EXT and core_stall = 1 in cycle 4, ext_ack cycle 5, core regranted cycle 5.
- Stalled core store: core store 0xAA to 0x030 during forced ext grant -> mem_write carries ext fields only; 0x030 written with 0xAA next cycle.
- Reset mid-operation: rst asserted in ext grant cycle -> ext_ack stays 0, ext_rdata = 0, starve_cnt = 0 after release.
- Byte store via ext: ext_store_type byte, ext_wdata 0x000000FF to 0x041 -> store_type passed unchanged to memory, only that byte changes on readback.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

  // Which requester owns the data-memory port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_EXT  = 2'd2
  } gnt_e;

  localparam int STORE_TYPE_W = 2;
  localparam int LOAD_TYPE_W  = 3;

  // Starvation counter width; the limit must fit (1..15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating up-counter with synchronous clear, used to bound how long
// ext can lose contention to the core.
module dmem_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int W     = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == W'(LIMIT));

  // Next count: clear wins over increment; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core (MEM stage) has priority, ext (loader/debug)
// gets a forced slot after STARVE_LIMIT lost contention cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_valid,
  input  logic                    core_mem_write,
  input  logic [STORE_TYPE_W-1:0] core_store_type,
  input  logic [LOAD_TYPE_W-1:0]  core_load_type,
  input  logic [ADDR_W-1:0]       core_addr,
  input  logic [31:0]             core_wdata,
  output logic [31:0]             core_rdata,
  output logic                    core_stall,
  input  logic                    ext_req,
  input  logic                    ext_we,
  input  logic [STORE_TYPE_W-1:0] ext_store_type,
  input  logic [LOAD_TYPE_W-1:0]  ext_load_type,
  input  logic [ADDR_W-1:0]       ext_addr,
  input  logic [31:0]             ext_wdata,
  output logic                    ext_ack,
  output logic [31:0]             ext_rdata,
  output logic                    mem_write,
  output logic [STORE_TYPE_W-1:0] mem_store_type,
  output logic [LOAD_TYPE_W-1:0]  mem_load_type,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_read_data
);

  gnt_e             gnt;
  logic             ext_ok;
  logic             ext_ack_q;
  logic             ext_ack_d;
  logic [31:0]      ext_rdata_q;
  logic [31:0]      ext_rdata_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             cnt_clr;
  logic             cnt_inc;

  // The ack cycle is a forced bubble so a held ext_req cannot be granted twice.
  assign ext_ok = ext_req & ~ext_ack_q;

  // Per-cycle grant: core first unless ext has waited long enough.
  always_comb begin
    gnt = GNT_NONE;
    if (ext_ok && (!core_valid || starve_hit)) begin
      gnt = GNT_EXT;
    end else if (core_valid) begin
      gnt = GNT_CORE;
    end
  end

  // Memory port mux; write enable only for the granted side.
  always_comb begin
    mem_addr       = core_addr;
    mem_wdata      = core_wdata;
    mem_store_type = core_store_type;
    mem_load_type  = core_load_type;
    mem_write      = 1'b0;
    case (gnt)
      GNT_EXT: begin
        mem_addr       = ext_addr;
        mem_wdata      = ext_wdata;
        mem_store_type = ext_store_type;
        mem_load_type  = ext_load_type;
        mem_write      = ext_we;
      end
      GNT_CORE: mem_write = core_mem_write;
      default:  mem_write = 1'b0;
    endcase
  end

  assign core_stall = core_valid & (gnt == GNT_EXT);
  assign core_rdata = mem_read_data;

  // Count only cycles where ext was eligible and lost to the core.
  assign cnt_clr = (gnt == GNT_EXT) | ~ext_ok;
  assign cnt_inc = (gnt == GNT_CORE) & ext_ok;

  dmem_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (starve_cnt),
    .at_limit (starve_hit)
  );

  // Ack pulse and ext load capture for the next edge.
  always_comb begin
    ext_ack_d   = (gnt == GNT_EXT);
    ext_rdata_d = ext_rdata_q;
    if ((gnt == GNT_EXT) && !ext_we) begin
      ext_rdata_d = mem_read_data;
    end
  end

  // Ext handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_ack_q   <= 1'b0;
      ext_rdata_q <= '0;
    end else begin
      ext_ack_q   <= ext_ack_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  assign ext_ack   = ext_ack_q;
  assign ext_rdata = ext_rdata_q;

endmodule
